// File: rtl/cheri_pkg.sv
// Shared types and constants for the TSMAP arbiter slice.
//   tsmap_arb_state_e : arbiter FSM states (IDLE, RMW_WB, SWEEP)
//   TsmapAw / TsmapDw : TSMAP word-address width and word width
//   sram_req_t        : one SRAM port command (select, write, be, addr, data)
//   be_to_mask        : expand 4 byte enables into a 32-bit bit mask
package cheri_pkg;

  localparam int unsigned TsmapAw = 16;
  localparam int unsigned TsmapDw = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RMW_WB = 2'd1,
    ST_SWEEP  = 2'd2
  } tsmap_arb_state_e;

  typedef struct packed {
    logic               cs;
    logic               we;
    logic [3:0]         be;
    logic [TsmapAw-1:0] addr;
    logic [TsmapDw-1:0] wdata;
  } sram_req_t;

  function automatic logic [TsmapDw-1:0] be_to_mask(input logic [3:0] be);
    logic [TsmapDw-1:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/cheri_tsmap_sweep.sv
// Clear-sweep engine: walks word addresses 0..TSMapSize-1, one write per
// unstalled cycle, and drops busy the cycle after the final write.
//   start  : accepted sweep start (already qualified by the arbiter)
//   stall  : a higher-priority requester owns the SRAM this cycle
//   busy   : sweep in progress (registered)
//   addr   : word address of the pending clear write
//   wr_c   : clear write issues this cycle
//   done_c : this cycle's write is the last one
module cheri_tsmap_sweep
  import cheri_pkg::*;
#(
  parameter int unsigned TSMapSize = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start,
  input  logic               stall,
  output logic               busy,
  output logic [TsmapAw-1:0] addr,
  output logic               wr_c,
  output logic               done_c
);

  localparam logic [TsmapAw-1:0] LastAddr = TsmapAw'(TSMapSize - 1);

  logic               busy_q;
  logic [TsmapAw-1:0] cnt_q;

  assign wr_c   = busy_q & ~stall;
  assign done_c = wr_c & (cnt_q == LastAddr);
  assign busy   = busy_q;
  assign addr   = cnt_q;

  // Counter only advances on cycles where the clear write actually issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (done_c) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (wr_c) begin
      cnt_q  <= cnt_q + TsmapAw'(1);
    end
  end

endmodule

// File: rtl/cheri_tsmap_arb.sv
// TSMAP SRAM arbiter/sequencer. Shares one single-port SRAM between the
// revocation read port (highest priority, never stalled), an atomic
// write-back, the clear sweep and the bus port, in that order.
// Optional feature macro: CHERI_TSMAP_BITOP_EN enables atomic bit-set writes
// (read in the grant cycle, OR-merge written back from RMW_WB).
//   trvk_*  : revocation read port, data = SRAM read data the next cycle
//   bus_*   : allocator bus port, combinational grant, 1-cycle response
//   clr_*   : sweep start pulse / busy flag
//   sram_*  : SRAM macro port (combinational command, 1-cycle read data)
module cheri_tsmap_arb
  import cheri_pkg::*;
#(
  parameter int unsigned TSMapSize = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        trvk_cs_i,
  input  logic [15:0] trvk_addr_i,
  output logic [31:0] trvk_rdata_o,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic        bus_atomic_i,
  input  logic [3:0]  bus_be_i,
  input  logic [15:0] bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic        bus_gnt_o,
  output logic        bus_rvalid_o,
  output logic [31:0] bus_rdata_o,
  output logic        bus_err_o,
  input  logic        clr_start_i,
  output logic        clr_busy_o,
  output logic        sram_cs_o,
  output logic        sram_we_o,
  output logic [3:0]  sram_be_o,
  output logic [15:0] sram_addr_o,
  output logic [31:0] sram_wdata_o,
  input  logic [31:0] sram_rdata_i
);

  tsmap_arb_state_e   state_q, state_d;
  sram_req_t          sram_c;
  logic               in_range_c;
  logic               atomic_c;
  logic               rmw_go_c;
  logic               rmw_wb_c;
  logic               sweep_start_c;
  logic               sw_busy, sw_wr_c, sw_done_c;
  logic [TsmapAw-1:0] sw_addr;
  logic               rsp_valid_q, rsp_err_q, rsp_rd_q;

  assign in_range_c   = 32'(bus_addr_i) < TSMapSize;
  assign rmw_go_c     = bus_gnt_o & atomic_c & in_range_c;
  assign trvk_rdata_o = sram_rdata_i;

`ifdef CHERI_TSMAP_BITOP_EN
  logic               rmw_rd_q;
  logic               rsp_atomic_q;
  logic [TsmapAw-1:0] rmw_addr_q;
  logic [TsmapDw-1:0] rmw_set_q;
  logic [TsmapDw-1:0] old_q;
  logic [TsmapDw-1:0] old_c;

  assign atomic_c = bus_atomic_i & bus_we_i;
  assign rmw_wb_c = (state_q == ST_RMW_WB) & ~trvk_cs_i;
  // The old word arrives on the SRAM bus only in the first RMW_WB cycle;
  // after that it is held locally in case trvk keeps stalling us.
  assign old_c    = rmw_rd_q ? sram_rdata_i : old_q;
`else
  logic unused_atomic;
  assign unused_atomic = bus_atomic_i;
  assign atomic_c      = 1'b0;
  assign rmw_wb_c      = 1'b0;
`endif

  // Sweep counter/busy/done live in the sub-module; trvk stalls it.
  cheri_tsmap_sweep #(
    .TSMapSize (TSMapSize)
  ) u_sweep (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start  (sweep_start_c),
    .stall  (trvk_cs_i),
    .busy   (sw_busy),
    .addr   (sw_addr),
    .wr_c   (sw_wr_c),
    .done_c (sw_done_c)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state, grant and SRAM command mux.
  always_comb begin
    state_d       = state_q;
    bus_gnt_o     = 1'b0;
    sweep_start_c = 1'b0;
    sram_c        = '0;

    case (state_q)
      ST_IDLE: begin
        bus_gnt_o = bus_req_i & ~trvk_cs_i & ~sw_busy;
        // A start colliding with an atomic grant is dropped: the FSM can
        // only take one of the two paths out of IDLE.
        if (rmw_go_c) begin
          state_d = ST_RMW_WB;
        end else if (clr_start_i && !sw_busy) begin
          sweep_start_c = 1'b1;
          state_d       = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (sw_done_c) state_d = ST_IDLE;
      end
`ifdef CHERI_TSMAP_BITOP_EN
      ST_RMW_WB: begin
        if (rmw_wb_c) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (trvk_cs_i) begin
      sram_c.cs   = 1'b1;
      sram_c.be   = 4'hF;
      sram_c.addr = trvk_addr_i;
`ifdef CHERI_TSMAP_BITOP_EN
    end else if (rmw_wb_c) begin
      sram_c.cs    = 1'b1;
      sram_c.we    = 1'b1;
      sram_c.be    = 4'hF;
      sram_c.addr  = rmw_addr_q;
      sram_c.wdata = old_c | rmw_set_q;
`endif
    end else if (sw_wr_c) begin
      sram_c.cs   = 1'b1;
      sram_c.we   = 1'b1;
      sram_c.be   = 4'hF;
      sram_c.addr = sw_addr;
    end else if (bus_gnt_o && in_range_c) begin
      // Atomic writes start with a read of the target word.
      sram_c.cs    = 1'b1;
      sram_c.we    = bus_we_i & ~atomic_c;
      sram_c.be    = bus_be_i;
      sram_c.addr  = bus_addr_i;
      sram_c.wdata = bus_wdata_i;
    end
  end

  assign sram_cs_o    = sram_c.cs;
  assign sram_we_o    = sram_c.we;
  assign sram_be_o    = sram_c.be;
  assign sram_addr_o  = sram_c.addr;
  assign sram_wdata_o = sram_c.wdata;
  assign clr_busy_o   = sw_busy;

  // Bus response tracking; atomics respond after their write-back instead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      rsp_valid_q <= (bus_gnt_o & ~rmw_go_c) | rmw_wb_c;
      rsp_err_q   <= bus_gnt_o & ~in_range_c;
      rsp_rd_q    <= bus_gnt_o & in_range_c & ~bus_we_i;
    end
  end

  assign bus_rvalid_o = rsp_valid_q;
  assign bus_err_o    = rsp_err_q;

`ifdef CHERI_TSMAP_BITOP_EN
  // Atomic sequencing state: target, bits to set and the captured old word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rmw_rd_q     <= 1'b0;
      rsp_atomic_q <= 1'b0;
      rmw_addr_q   <= '0;
      rmw_set_q    <= '0;
      old_q        <= '0;
    end else begin
      rmw_rd_q     <= rmw_go_c;
      rsp_atomic_q <= rmw_wb_c;
      if (rmw_go_c) begin
        rmw_addr_q <= bus_addr_i;
        rmw_set_q  <= bus_wdata_i & be_to_mask(bus_be_i);
      end
      if (state_q == ST_RMW_WB) old_q <= old_c;
    end
  end

  assign bus_rdata_o = rsp_rd_q ? sram_rdata_i : (rsp_atomic_q ? old_q : '0);
`else
  assign bus_rdata_o = rsp_rd_q ? sram_rdata_i : '0;
`endif

endmodule

// File: tb/tb_cheri_tsmap_arb.sv
// Self-checking bench for cheri_tsmap_arb (TSMapSize = 16) with a behavioural
// SRAM and a word-array reference model of the map contents.
module tb_cheri_tsmap_arb;

  localparam int unsigned N = 16;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        trvk_cs_i = 1'b0;
  logic [15:0] trvk_addr_i = '0;
  logic [31:0] trvk_rdata_o;
  logic        bus_req_i = 1'b0;
  logic        bus_we_i = 1'b0;
  logic        bus_atomic_i = 1'b0;
  logic [3:0]  bus_be_i = '0;
  logic [15:0] bus_addr_i = '0;
  logic [31:0] bus_wdata_i = '0;
  logic        bus_gnt_o;
  logic        bus_rvalid_o;
  logic [31:0] bus_rdata_o;
  logic        bus_err_o;
  logic        clr_start_i = 1'b0;
  logic        clr_busy_o;
  logic        sram_cs_o;
  logic        sram_we_o;
  logic [3:0]  sram_be_o;
  logic [15:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cheri_tsmap_arb #(.TSMapSize(N)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .trvk_cs_i    (trvk_cs_i),
    .trvk_addr_i  (trvk_addr_i),
    .trvk_rdata_o (trvk_rdata_o),
    .bus_req_i    (bus_req_i),
    .bus_we_i     (bus_we_i),
    .bus_atomic_i (bus_atomic_i),
    .bus_be_i     (bus_be_i),
    .bus_addr_i   (bus_addr_i),
    .bus_wdata_i  (bus_wdata_i),
    .bus_gnt_o    (bus_gnt_o),
    .bus_rvalid_o (bus_rvalid_o),
    .bus_rdata_o  (bus_rdata_o),
    .bus_err_o    (bus_err_o),
    .clr_start_i  (clr_start_i),
    .clr_busy_o   (clr_busy_o),
    .sram_cs_o    (sram_cs_o),
    .sram_we_o    (sram_we_o),
    .sram_be_o    (sram_be_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i)
  );

  // Behavioural single-port SRAM, one-cycle read latency.
  logic [31:0] mem [N];
  int          cs_cnt  = 0;
  int          oob_cnt = 0;
  always @(posedge clk) begin
    if (sram_cs_o) begin
      cs_cnt++;
      if (32'(sram_addr_o) >= N) oob_cnt++;
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_be_o[b]) mem[sram_addr_o[3:0]][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end else begin
        sram_rdata_i <= mem[sram_addr_o[3:0]];
      end
    end
  end

  // Reference map contents.
  logic [31:0] ref_mem [N];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bus transaction; reports cycles waited for the grant and response latency.
  task automatic bus_op(input logic we, input logic atomic, input logic [3:0] be,
                        input logic [15:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int wait_cyc, output int lat);
    @(negedge clk);
    bus_req_i = 1'b1; bus_we_i = we; bus_atomic_i = atomic;
    bus_be_i = be; bus_addr_i = addr; bus_wdata_i = wdata;
    #1;
    wait_cyc = 0;
    while (!bus_gnt_o && wait_cyc < 50) begin
      @(negedge clk); #1; wait_cyc++;
    end
    if (!bus_gnt_o) chk("gnt_timeout", 32'(bus_gnt_o), 32'd1);
    @(negedge clk);
    bus_req_i = 1'b0; bus_we_i = 1'b0; bus_atomic_i = 1'b0;
    #1;
    lat = 1;
    while (!bus_rvalid_o && lat < 50) begin
      @(negedge clk); #1; lat++;
    end
    if (!bus_rvalid_o) chk("rvalid_timeout", 32'(bus_rvalid_o), 32'd1);
    rdata = bus_rdata_o;
    err   = bus_err_o;
  endtask

  task automatic trvk_rd(input string name, input logic [15:0] addr, input logic [31:0] exp);
    @(negedge clk);
    trvk_cs_i = 1'b1; trvk_addr_i = addr;
    @(negedge clk);
    trvk_cs_i = 1'b0;
    #1;
    chk(name, trvk_rdata_o, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},   32'(bus_gnt_o),    32'd0);
    chk({tag, "_rvalid"},32'(bus_rvalid_o), 32'd0);
    chk({tag, "_rdata"}, bus_rdata_o,       32'd0);
    chk({tag, "_err"},   32'(bus_err_o),    32'd0);
    chk({tag, "_busy"},  32'(clr_busy_o),   32'd0);
    chk({tag, "_cs"},    32'(sram_cs_o),    32'd0);
    chk({tag, "_we"},    32'(sram_we_o),    32'd0);
    chk({tag, "_be"},    32'(sram_be_o),    32'd0);
    chk({tag, "_addr"},  32'(sram_addr_o),  32'd0);
    chk({tag, "_wdata"}, sram_wdata_o,      32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t        vecs [11];
    logic [31:0] rd;
    logic        er;
    int          w, l, cs0, c, busy_cycles, gnt_cyc, gnt_bad;

    vecs[0]  = '{1'b1, 4'hF,   16'd5,      32'hA5A5_0001, 32'h0,          1'b0};
    vecs[1]  = '{1'b0, 4'hF,   16'd5,      32'h0,         32'hA5A5_0001, 1'b0};
    vecs[2]  = '{1'b1, 4'hF,   16'd7,      32'h1122_3344, 32'h0,          1'b0};
    vecs[3]  = '{1'b1, 4'b0101,16'd7,      32'hAABB_CCDD, 32'h0,          1'b0};
    vecs[4]  = '{1'b0, 4'hF,   16'd7,      32'h0,         32'h11BB_33DD, 1'b0};
    vecs[5]  = '{1'b1, 4'hF,   16'd16,     32'hFFFF_FFFF, 32'h0,          1'b1};
    vecs[6]  = '{1'b0, 4'hF,   16'd16,     32'h0,         32'h0,          1'b1};
    vecs[7]  = '{1'b0, 4'hF,   16'hFFFF,   32'h0,         32'h0,          1'b1};
    vecs[8]  = '{1'b1, 4'hF,   16'd0,      32'h1357_9BDF, 32'h0,          1'b0};
    vecs[9]  = '{1'b1, 4'hF,   16'd10,     32'hDEAD_BEEF, 32'h0,          1'b0};
    vecs[10] = '{1'b0, 4'hF,   16'd0,      32'h0,         32'h1357_9BDF, 1'b0};
    for (int i = 0; i < int'(N); i++) ref_mem[i] = 32'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_ni = 1'b1;

    // Directed bus vectors.
    for (int i = 0; i < 11; i++) begin
      cs0 = cs_cnt;
      bus_op(vecs[i].we, 1'b0, vecs[i].be, vecs[i].addr, vecs[i].wdata, rd, er, w, l);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_gnt_wait", i), 32'(w), 32'd0);
      chk($sformatf("vec%0d_lat", i), 32'(l), 32'd1);
      chk($sformatf("vec%0d_sram_cs", i), 32'(cs_cnt - cs0), vecs[i].exp_err ? 32'd0 : 32'd1);
      if (vecs[i].we && !vecs[i].exp_err)
        ref_mem[vecs[i].addr[3:0]] = merge(ref_mem[vecs[i].addr[3:0]], vecs[i].wdata, vecs[i].be);
    end

    // trvk blocks the bus for three cycles without disturbing its own data.
    @(negedge clk);
    trvk_cs_i = 1'b1; trvk_addr_i = 16'd5;
    bus_req_i = 1'b1; bus_we_i = 1'b0; bus_be_i = 4'hF; bus_addr_i = 16'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("coll_gnt%0d", i), 32'(bus_gnt_o), 32'd0);
      if (i > 0) chk($sformatf("coll_trvk%0d", i), trvk_rdata_o, ref_mem[5]);
      @(negedge clk);
    end
    trvk_cs_i = 1'b0;
    #1;
    chk("coll_gnt3", 32'(bus_gnt_o), 32'd1);
    chk("coll_trvk3", trvk_rdata_o, ref_mem[5]);
    @(negedge clk);
    bus_req_i = 1'b0;
    #1;
    chk("coll_rvalid", 32'(bus_rvalid_o), 32'd1);
    chk("coll_rdata", bus_rdata_o, ref_mem[7]);

    // Sweep with two trvk stalls and a bus request waiting behind it.
    @(negedge clk);
    clr_start_i = 1'b1;
    #1;
    busy_cycles = 0; gnt_cyc = -1; gnt_bad = 0;
    for (c = 1; c < 60 && gnt_cyc < 0; c++) begin
      @(negedge clk);
      clr_start_i = 1'b0;
      bus_req_i = 1'b1; bus_we_i = 1'b0; bus_be_i = 4'hF; bus_addr_i = 16'd2;
      trvk_cs_i = (c == 4) || (c == 9);
      trvk_addr_i = (c == 4) ? 16'd10 : 16'd0;
      #1;
      if (c == 5)  chk("sweep_trvk_uncleared", trvk_rdata_o, ref_mem[10]);
      if (c == 10) chk("sweep_trvk_cleared", trvk_rdata_o, 32'h0);
      if (clr_busy_o) begin
        busy_cycles++;
        if (bus_gnt_o) gnt_bad++;
      end else if (bus_gnt_o) begin
        gnt_cyc = c;
      end
    end
    @(negedge clk);
    bus_req_i = 1'b0;
    #1;
    chk("sweep_busy_cycles", 32'(busy_cycles), 32'd18);
    chk("sweep_gnt_during_busy", 32'(gnt_bad), 32'd0);
    chk("sweep_gnt_cycle", 32'(gnt_cyc), 32'd19);
    chk("sweep_bus_rvalid", 32'(bus_rvalid_o), 32'd1);
    chk("sweep_bus_rdata", bus_rdata_o, 32'h0);
    for (int i = 0; i < int'(N); i++) ref_mem[i] = 32'h0;
    for (int i = 0; i < int'(N); i++) trvk_rd($sformatf("sweep_word%0d", i), 16'(i), 32'h0);

    // Randomised traffic against the reference map.
    for (int i = 0; i < 80; i++) begin
      logic [15:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      int          kind;
      kind = $urandom_range(0, 2);
      a    = 16'($urandom_range(0, 19));
      wd   = $urandom;
      be   = 4'($urandom_range(0, 15));
      if (kind == 2) begin
        a = {12'h0, a[3:0]};
        trvk_rd($sformatf("rnd%0d_trvk", i), a, ref_mem[a[3:0]]);
      end else begin
        bus_op(kind == 0, 1'b0, be, a, wd, rd, er, w, l);
        chk($sformatf("rnd%0d_err", i), 32'(er), (32'(a) >= N) ? 32'd1 : 32'd0);
        chk($sformatf("rnd%0d_rdata", i), rd,
            (kind == 1 && 32'(a) < N) ? ref_mem[a[3:0]] : 32'h0);
        if (kind == 0 && 32'(a) < N) ref_mem[a[3:0]] = merge(ref_mem[a[3:0]], wd, be);
      end
    end

    // Atomic bit-set with a trvk collision on the write-back cycle.
    bus_op(1'b1, 1'b0, 4'hF, 16'd3, 32'h0000_00F0, rd, er, w, l);
    ref_mem[3] = 32'h0000_00F0;
    @(negedge clk);
    bus_req_i = 1'b1; bus_we_i = 1'b1; bus_atomic_i = 1'b1;
    bus_be_i = 4'hF; bus_addr_i = 16'd3; bus_wdata_i = 32'h0000_0101;
    #1;
    chk("atom_gnt", 32'(bus_gnt_o), 32'd1);
    @(negedge clk);
    bus_req_i = 1'b0; bus_atomic_i = 1'b0; bus_we_i = 1'b0;
    trvk_cs_i = 1'b1; trvk_addr_i = 16'd3;
    #1;
`ifdef CHERI_TSMAP_BITOP_EN
    chk("atom_rvalid_g1", 32'(bus_rvalid_o), 32'd0);
    @(negedge clk);
    trvk_cs_i = 1'b0;
    bus_req_i = 1'b1; bus_addr_i = 16'd5;
    #1;
    chk("atom_trvk_old", trvk_rdata_o, 32'h0000_00F0);
    chk("atom_no_gnt_rmw", 32'(bus_gnt_o), 32'd0);
    chk("atom_rvalid_g2", 32'(bus_rvalid_o), 32'd0);
    @(negedge clk);
    bus_req_i = 1'b0;
    #1;
    chk("atom_rvalid_g3", 32'(bus_rvalid_o), 32'd1);
    chk("atom_rdata", bus_rdata_o, 32'h0000_00F0);
    chk("atom_err", 32'(bus_err_o), 32'd0);
    ref_mem[3] = 32'h0000_01F1;
`else
    chk("atom_plain_rvalid", 32'(bus_rvalid_o), 32'd1);
    chk("atom_plain_rdata", bus_rdata_o, 32'h0);
    @(negedge clk);
    trvk_cs_i = 1'b0;
    #1;
    chk("atom_plain_trvk", trvk_rdata_o, 32'h0000_0101);
    ref_mem[3] = 32'h0000_0101;
`endif
    bus_op(1'b0, 1'b0, 4'hF, 16'd3, 32'h0, rd, er, w, l);
    chk("atom_readback", rd, ref_mem[3]);

    // Reset in the middle of a sweep, then an immediate restart.
    @(negedge clk);
    clr_start_i = 1'b1;
    @(negedge clk);
    clr_start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_ni = 1'b1;
    clr_start_i = 1'b1;
    @(negedge clk);
    clr_start_i = 1'b0;
    #1;
    chk("midrst_restart_busy", 32'(clr_busy_o), 32'd1);
    busy_cycles = 0;
    while (clr_busy_o && busy_cycles < 40) begin
      busy_cycles++;
      @(negedge clk); #1;
    end
    chk("midrst_sweep_len", 32'(busy_cycles), 32'd16);
    trvk_rd("midrst_word9", 16'd9, 32'h0);
    chk("sram_oob_access", 32'(oob_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cheri_tsmap_arb.md
# cheri_tsmap_arb

Arbiter and sequencer for the single-port temporal-safety map (TSMAP) SRAM. It shares the SRAM between three requesters: the load-revocation pipeline read port (fixed latency, never stalled), a bus-side read/write port used by the allocator, and an internal clear-sweep engine that zeroes the whole map. It sits between the revocation stage, the TSMAP bus slave and the SRAM macro.

## Interface
Parameters:
- TSMapSize, 1024: number of 32-bit map words; valid word addresses are 0..TSMapSize-1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- trvk_cs_i  in  1  revocation-stage read request.
- trvk_addr_i  in  16  revocation-stage word address.
- trvk_rdata_o  out  32  read data, valid the cycle after trvk_cs_i.
- bus_req_i  in  1  bus request.
- bus_we_i  in  1  bus write.
- bus_atomic_i  in  1  atomic bit-set write (see Configuration).
- bus_be_i  in  4  byte enables.
- bus_addr_i  in  16  bus word address.
- bus_wdata_i  in  32  bus write data.
- bus_gnt_o  out  1  grant.
- bus_rvalid_o  out  1  response valid.
- bus_rdata_o  out  32  response data.
- bus_err_o  out  1  response error, qualified by bus_rvalid_o.
- clr_start_i  in  1  start clear sweep (pulse).
- clr_busy_o  out  1  sweep in progress.
- sram_cs_o, sram_we_o  out  1 each  SRAM select / write.
- sram_be_o  out  4  SRAM byte enables.
- sram_addr_o  out  16  SRAM word address.
- sram_wdata_o  out  32  SRAM write data.
- sram_rdata_i  in  32  SRAM read data, valid one cycle after a read select.

## Operation
- Priority per cycle: trvk_cs_i > RMW write-back > sweep write > bus.
- A trvk read is never stalled or refused. trvk_rdata_o = sram_rdata_i, passed through combinationally.
- bus_gnt_o = bus_req_i & ~trvk_cs_i & FSM in IDLE & ~clr_busy_o. The grant is combinational, and the SRAM access happens in the grant cycle.
- Bus address >= TSMapSize: the request is granted but no SRAM access is made. The response is err=1 with rdata 0.
- Bus read: rdata comes from sram_rdata_i on the response cycle. Bus write: response rdata = 0.
- The sweep is accepted only when clr_busy_o=0 and the FSM is in IDLE. Otherwise clr_start_i is ignored.
- Sweep behaviour:
  - clr_busy_o rises the next cycle.
  - A word counter runs 0..TSMapSize-1 and writes 32'h0 with be=4'hF on every cycle trvk_cs_i=0.
  - clr_busy_o falls the cycle after the final write.
- A trvk read during the sweep returns the current contents, whether or not that word is cleared yet.
- FSM states: IDLE, RMW_WB (macro only), SWEEP.
  - IDLE -> SWEEP on an accepted clr_start_i.
  - SWEEP -> IDLE after the last write.
  - IDLE -> RMW_WB on a granted in-range atomic write.
  - RMW_WB -> IDLE once the write-back issues.
- Reset mid-operation: all state clears and any sweep is abandoned. The map contents are undefined.

## Timing
- Reset values: bus_gnt_o (registered part)=0, bus_rvalid_o=0, bus_rdata_o=0, bus_err_o=0, clr_busy_o=0, sram_cs_o=0, sram_we_o=0, sram_be_o=0, sram_addr_o=0, sram_wdata_o=0. FSM=IDLE, counter=0.
- Bus read/write latency: rvalid exactly one cycle after the grant. Back-to-back grants are allowed.
- Sweep duration: TSMapSize + (number of trvk cycles during the sweep) cycles.
- Atomic write latency: rvalid two or more cycles after the grant, delayed by any trvk collisions on the write-back.

## Configuration
- CHERI_TSMAP_BITOP_EN defined:
  - A granted in-range write with bus_atomic_i=1 performs a read in the grant cycle.
  - It then enters RMW_WB and writes (old | (bus_wdata_i masked by bus_be_i)) on the first cycle without trvk_cs_i.
  - rvalid is asserted the cycle after the write-back, with rdata = old word.
  - No grant is given while in RMW_WB.
  - A trvk read of the same word before the write-back sees the old value.
- Undefined: bus_atomic_i is ignored, RMW_WB does not exist, and an atomic write behaves as a plain write.

## Structure
- cheri_pkg holds the FSM state enum (tsmap_arb_state_e) and the TSMAP word-address width constant.
- One sub-module: cheri_tsmap_sweep. It contains the counter, the busy flag and the done logic, and is driven with a stall input (= trvk_cs_i).

## Test plan
- Bus read of word 5 (preloaded 32'hA5A5_0001) with trvk idle -> gnt the same cycle, rvalid+1 with rdata 32'hA5A5_0001, err=0.
- trvk_cs_i and bus_req_i high together for 3 cycles -> gnt=0 for those 3 cycles, gnt in cycle 4, and trvk data is never disturbed.
- Bus write to address TSMapSize -> gnt, rvalid+1 with err=1, sram_cs_o never asserted.
- Sweep with TSMapSize=16 and trvk_cs_i pulsed twice mid-sweep -> clr_busy_o high for 18 cycles, all words read back 0, and a bus_req during the sweep is granted only after clr_busy_o falls.
- Macro on: word 3 = 32'h0000_00F0, atomic write wdata 32'h0000_0101 be=4'hF, trvk collision on the write-back cycle -> word 3 = 32'h0000_01F1, rdata 32'h0000_00F0, rvalid at grant+3.
- Assert rst_ni mid-sweep -> all outputs at reset values, and clr_start_i is accepted the first cycle after release.
